// File: rtl/hbridge_pkg.sv
// Shared direction encodings and per-channel FSM state type for the H-bridge driver.
package hbridge_pkg;
  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_BAD   = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_DEAD} ch_state_t;

  function automatic logic dir_valid(input logic [1:0] d);
    return (d == DIR_FWD) || (d == DIR_REV);
  endfunction
endpackage

// File: rtl/hbridge_channel.sv
// One H-bridge channel: IDLE/DRIVE/DEAD FSM, dead-time counter and optional soft-start
// ramp (HBRIDGE_SOFTSTART_EN). All outputs are registered.
module hbridge_channel
  import hbridge_pkg::*;
#(
  parameter int DEADTIME = 50
`ifdef HBRIDGE_SOFTSTART_EN
  , parameter int RAMP_STEP = 64
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cmd,
  input  logic       en,
  input  logic [7:0] cnt,
  input  logic [7:0] duty_frame,
  output logic [1:0] pair,
  output logic       pwm_en,
  output logic       busy
);
  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  ch_state_t     state;
  logic [1:0]    dir;
  logic [DW-1:0] dcnt;
  logic [7:0]    duty_eff;
  logic          pwm;

`ifdef HBRIDGE_SOFTSTART_EN
  localparam int RW = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;
  logic [7:0]    ramp;
  logic [RW-1:0] scnt;

  // Ramp only advances while driving; IDLE/DEAD hold it at zero so DRIVE entry starts from 0.
  always_ff @(posedge clk) begin
    if (rst || state != ST_DRIVE) begin
      ramp <= '0;
      scnt <= '0;
    end else if (ramp > duty_frame) begin
      ramp <= duty_frame;
      scnt <= '0;
    end else if (scnt == RW'(RAMP_STEP - 1)) begin
      scnt <= '0;
      if (ramp < duty_frame) ramp <= ramp + 8'd1;
    end else begin
      scnt <= scnt + 1'b1;
    end
  end

  assign duty_eff = (ramp > duty_frame) ? duty_frame : ramp;
`else
  assign duty_eff = duty_frame;
`endif

  assign pwm = cnt < duty_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      dir    <= DIR_COAST;
      dcnt   <= '0;
      pair   <= DIR_COAST;
      pwm_en <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (en && dir_valid(cmd)) begin
          state  <= ST_DRIVE;
          dir    <= cmd;
          pair   <= cmd;
          pwm_en <= pwm;
        end
        // dir is only ever FWD/REV, so a coast or invalid pair always mismatches it
        ST_DRIVE: if (!en || cmd != dir) begin
          state  <= ST_DEAD;
          dcnt   <= '0;
          pair   <= DIR_COAST;
          pwm_en <= 1'b0;
          busy   <= 1'b1;
        end else begin
          pwm_en <= pwm;
        end
        ST_DEAD: if (dcnt == DW'(DEADTIME - 1)) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
        default: begin
          state  <= ST_IDLE;
          pair   <= DIR_COAST;
          pwm_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/hbridge_driver.sv
// Dual-channel H-bridge driver: shared frame-synchronised PWM counter, sticky fault flag,
// two hbridge_channel instances. Optional soft start via HBRIDGE_SOFTSTART_EN.
module hbridge_driver
  import hbridge_pkg::*;
#(
  parameter int PWM_PERIOD = 256,
  parameter int DEADTIME   = 50,
  parameter int RAMP_STEP  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] motorIn,
  input  logic [1:0] motorEn,
  input  logic [7:0] duty,
  output logic [3:0] bridge_in,
  output logic [1:0] bridge_en,
  output logic [1:0] busy,
  output logic       fault
);
  if (PWM_PERIOD < 2 || PWM_PERIOD > 256 || DEADTIME < 1 || RAMP_STEP < 1) begin : g_bad_cfg
    $error("hbridge_driver: parameter out of range");
  end

  logic [7:0] cnt;
  logic [7:0] duty_frame;

  // duty is captured whenever the counter is about to be 0, so a frame never changes width midway
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      duty_frame <= duty;
      fault      <= 1'b0;
    end else begin
      if (cnt == 8'(PWM_PERIOD - 1)) begin
        cnt        <= '0;
        duty_frame <= duty;
      end else begin
        cnt <= cnt + 8'd1;
      end
      fault <= fault | (motorIn[3:2] == DIR_BAD) | (motorIn[1:0] == DIR_BAD);
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    hbridge_channel #(
      .DEADTIME (DEADTIME)
`ifdef HBRIDGE_SOFTSTART_EN
      , .RAMP_STEP(RAMP_STEP)
`endif
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .cmd        (motorIn[2*c+1:2*c]),
      .en         (motorEn[c]),
      .cnt        (cnt),
      .duty_frame (duty_frame),
      .pair       (bridge_in[2*c+1:2*c]),
      .pwm_en     (bridge_en[c]),
      .busy       (busy[c])
    );
  end
endmodule
